// File: rtl/br_pkg.sv
// Shared types and defaults for the register bank loader.
// State encoding is fixed so the state register is easy to read on a waveform.
package br_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } br_state_t;

    localparam int NREG_DEFAULT   = 32;
    localparam int AW_DEFAULT     = 5;
    localparam int DW_DEFAULT     = 32;
    localparam int BYTES_PER_WORD = DW_DEFAULT / 8;

endpackage

// File: rtl/br_word_assembler.sv
// Packs accepted bytes MSB-first into a DW-bit word and flags the byte
// that completes the word.
module br_word_assembler
    import br_pkg::*;
#(
    parameter int DW  = DW_DEFAULT,
    parameter int BPW = BYTES_PER_WORD
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          accept,
    input  logic [7:0]    byte_in,
    output logic [DW-1:0] word,
    output logic          word_complete
);

    localparam int CW = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CW-1:0] byte_cnt;
    logic          last_byte;

    assign last_byte     = (int'(byte_cnt) == BPW - 1);
    assign word_complete = accept && !clear && last_byte;

    // NOTE: the word register is reset because it drives the bank data port
    // directly; a plain shift register without reset would leak X out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= '0;
            word     <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
            word     <= '0;
        end else if (accept) begin
            // Truncating the concatenation drops the oldest byte.
            word     <= DW'({word, byte_in});
            byte_cnt <= last_byte ? '0 : byte_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/br_loader.sv
// Loads the register bank from a byte stream: RECV assembles a word, WRITE
// pulses regwrite for one cycle, addresses walk upward from FIRST_REG.
module br_loader
    import br_pkg::*;
#(
    parameter int NREG      = NREG_DEFAULT,
    parameter int AW        = AW_DEFAULT,
    parameter int DW        = DW_DEFAULT,
    parameter int FIRST_REG = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [7:0]    byte_in,
    input  logic          byte_valid,
    output logic          byte_ready,
    output logic [AW-1:0] escritura,
    output logic [DW-1:0] dato_a_escribir,
    output logic          regwrite,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   count
);

    localparam int LAST_REG = FIRST_REG + NREG - 1;

    generate
        if (NREG < 1 || NREG > 32 || FIRST_REG < 0 || LAST_REG > (1 << AW) - 1 ||
            DW < 8 || (DW % 8) != 0) begin : g_bad_params
            $error("br_loader: illegal NREG/FIRST_REG/AW/DW combination");
        end
    endgenerate

    localparam logic [AW-1:0] FIRST_ADDR = AW'(FIRST_REG);
    localparam logic [AW-1:0] LAST_ADDR  = AW'(LAST_REG);

    br_state_t state, state_nxt;
    logic      load_start;
    logic      accept;
    logic      asm_clear;
    logic      word_complete;

    // abort outranks start in IDLE and DONE as well as during a load.
    assign load_start = ((state == IDLE) || (state == DONE)) && start && !abort;
    assign accept     = byte_valid && byte_ready;
    assign asm_clear  = (state != RECV) || abort;

    br_word_assembler #(
        .DW  (DW),
        .BPW (DW / 8)
    ) u_assembler (
        .clk           (clk),
        .rst           (rst),
        .clear         (asm_clear),
        .accept        (accept),
        .byte_in       (byte_in),
        .word          (dato_a_escribir),
        .word_complete (word_complete)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path through it can leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        regwrite   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (load_start) state_nxt = RECV;
            end
            RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (abort)              state_nxt = IDLE;
                else if (word_complete) state_nxt = WRITE;
            end
            WRITE: begin
                busy = 1'b1;
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    regwrite  = 1'b1;
                    state_nxt = (escritura == LAST_ADDR) ? DONE : RECV;
                end
            end
            DONE: begin
                done = 1'b1;
                if (load_start) state_nxt = RECV;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            escritura <= FIRST_ADDR;
            count     <= '0;
        end else if (load_start) begin
            escritura <= FIRST_ADDR;
            count     <= '0;
        end else if (state == WRITE && !abort) begin
            count <= count + (AW + 1)'(1);
            // The last address is held so the bank port shows where the load ended.
            if (escritura != LAST_ADDR) escritura <= escritura + AW'(1);
        end
    end

endmodule
